// File: rtl/hex_text_writer.sv
// Formats a 32-bit word as ASCII hex and streams it into the Terminal text buffer, one character per cycle.
// Optional "0x" prefix ahead of the digits when HEX_TEXT_WRITER_PREFIX_EN is defined.
module hex_text_writer #(
  parameter int DIGITS    = 8,
  parameter int TEXT_SIZE = 2400,
  parameter int UPPERCASE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic [11:0] baseAddress,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic [11:0] textAddress,
  output logic        shouldWriteText,
  output logic [7:0]  textWriteData
);

`ifdef HEX_TEXT_WRITER_PREFIX_EN
  localparam int PREFIX = 2;
`else
  localparam int PREFIX = 0;
`endif
  localparam int TOTAL = DIGITS + PREFIX;
  localparam logic [3:0]  IDX_FIRST = 4'(TOTAL - 1);
  localparam logic [11:0] SIZE_W    = 12'(TEXT_SIZE);
  localparam logic [11:0] LAST_CELL = 12'(TEXT_SIZE - 1);
  localparam logic [7:0]  ALPHA_OFS = (UPPERCASE != 0) ? 8'h37 : 8'h57;

  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] value_reg, value_next;
  logic [11:0] addr_reg, addr_next;
  logic [3:0]  idx_reg, idx_next;

  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        wr_reg, wr_next;
  logic [11:0] taddr_reg, taddr_next;
  logic [7:0]  tdata_reg, tdata_next;

  logic [3:0]  cur_nibble;
  logic [7:0]  cur_char;

  // idx_reg counts the remaining character slot; digit slots map directly to nibble indices.
  assign cur_nibble = 4'(value_reg >> {idx_reg, 2'b00});

  always_comb begin
    cur_char = (cur_nibble < 4'd10) ? (8'h30 + {4'h0, cur_nibble})
                                    : (ALPHA_OFS + {4'h0, cur_nibble});
`ifdef HEX_TEXT_WRITER_PREFIX_EN
    if (idx_reg == IDX_FIRST)
      cur_char = 8'h30;
    else if (idx_reg == IDX_FIRST - 4'd1)
      cur_char = 8'h78;
`endif
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      value_reg <= '0;
      addr_reg  <= '0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      wr_reg    <= 1'b0;
      taddr_reg <= '0;
      tdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      addr_reg  <= addr_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      wr_reg    <= wr_next;
      taddr_reg <= taddr_next;
      tdata_reg <= tdata_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    addr_next  = addr_reg;
    idx_next   = idx_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WRITE;
          value_next = value;
          // 12-bit base is always below 2*TEXT_SIZE, so one subtraction reduces it.
          addr_next  = (baseAddress >= SIZE_W) ? (baseAddress - SIZE_W) : baseAddress;
          idx_next   = IDX_FIRST;
        end
      end
      WRITE: begin
        if (!hold) begin
          addr_next = (addr_reg == LAST_CELL) ? 12'd0 : (addr_reg + 12'd1);
          if (idx_reg == 4'd0)
            state_next = FINISH;
          else
            idx_next = idx_reg - 4'd1;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are decoded from the current state
  always_comb begin
    busy_next  = (state_reg == WRITE);
    done_next  = (state_reg == FINISH);
    wr_next    = (state_reg == WRITE) && !hold;
    taddr_next = taddr_reg;
    tdata_next = tdata_reg;
    if (wr_next) begin
      taddr_next = addr_reg;
      tdata_next = cur_char;
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign shouldWriteText = wr_reg;
  assign textAddress     = taddr_reg;
  assign textWriteData   = tdata_reg;

endmodule

// File: tb/tb_hex_text_writer.sv
// Directed and randomized bench for hex_text_writer: an 8-digit uppercase instance and a 4-digit lowercase instance.
module tb_hex_text_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] value = '0;
  logic [11:0] baseAddress = '0;
  logic        hold = 1'b0;

  logic        busy_a, done_a, wr_a, busy_b, done_b, wr_b;
  logic [11:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;

  int checks = 0;
  int errors = 0;

  always #20 clock = ~clock;

  hex_text_writer #(.DIGITS(8), .TEXT_SIZE(2400), .UPPERCASE(1)) u_hex (
    .clock(clock), .reset(reset), .start(start_a), .value(value), .baseAddress(baseAddress),
    .hold(hold), .busy(busy_a), .done(done_a), .textAddress(addr_a),
    .shouldWriteText(wr_a), .textWriteData(data_a));

  hex_text_writer #(.DIGITS(4), .TEXT_SIZE(2400), .UPPERCASE(0)) u_lc (
    .clock(clock), .reset(reset), .start(start_b), .value(value), .baseAddress(baseAddress),
    .hold(hold), .busy(busy_b), .done(done_b), .textAddress(addr_b),
    .shouldWriteText(wr_b), .textWriteData(data_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected text built from the printed hex representation of the value.
  function automatic string exp_text(input int which, input logic [31:0] v);
    string s;
    int d;
    s = $sformatf("%08h", v);
    d = (which == 0) ? 8 : 4;
    s = s.substr(8 - d, 7);
    if (which == 0) s = s.toupper();
`ifdef HEX_TEXT_WRITER_PREFIX_EN
    s = {"0x", s};
`endif
    return s;
  endfunction

  task automatic sample(input int which, output logic w, output logic [11:0] a,
                        output logic [7:0] d, output logic bz, output logic dn);
    if (which == 0) begin
      w = wr_a; a = addr_a; d = data_a; bz = busy_a; dn = done_a;
    end else begin
      w = wr_b; a = addr_b; d = data_b; bz = busy_b; dn = done_b;
    end
  endtask

  task automatic set_start(input int which, input logic s);
    if (which == 0) start_a = s; else start_b = s;
  endtask

  task automatic run_req(input int which, input logic [31:0] v, input logic [11:0] b,
                         input int hold_after, input int hold_len, input bit rand_hold,
                         input int abort_after, input bit retrigger);
    string txt;
    int n, presented, held, cycles, first_cell;
    logic h, w, bz, dn;
    logic [11:0] a;
    logic [7:0] d;
    txt = exp_text(which, v);
    n = txt.len();
    first_cell = int'(b) % 2400;
    @(negedge clock);
    value = v; baseAddress = b; hold = 1'b0;
    set_start(which, 1'b1);
    @(posedge clock); #1;
    set_start(which, 1'b0);
    value = $urandom; baseAddress = 12'($urandom);
    sample(which, w, a, d, bz, dn);
    chk("accept_strobe", 32'(w), 32'd0);
    presented = 0; held = 0; cycles = 0;
    while (presented < n) begin
      @(negedge clock);
      h = 1'b0;
      if (presented == hold_after && held < hold_len) begin
        h = 1'b1; held++;
      end else if (rand_hold && $urandom_range(0, 3) == 0) begin
        h = 1'b1;
      end
      hold = h;
      if (retrigger && presented == 3) begin
        value = 32'h12345678; baseAddress = 12'd7;
        set_start(which, 1'b1);
      end else begin
        set_start(which, 1'b0);
      end
      @(posedge clock); #1;
      sample(which, w, a, d, bz, dn);
      if (!h) begin
        chk($sformatf("strobe[%0d]", presented), 32'(w), 32'd1);
        chk($sformatf("addr[%0d]", presented), 32'(a), 32'((first_cell + presented) % 2400));
        chk($sformatf("data[%0d]", presented), 32'(d), 32'(txt[presented]));
        chk("busy_write", 32'(bz), 32'd1);
        chk("done_early", 32'(dn), 32'd0);
        presented++;
      end else begin
        chk("hold_strobe", 32'(w), 32'd0);
        chk("hold_busy", 32'(bz), 32'd1);
      end
      if (abort_after > 0 && presented == abort_after) begin
        hold = 1'b0; set_start(which, 1'b0);
        #5 reset = 1'b0;
        #1;
        sample(which, w, a, d, bz, dn);
        chk("abort_strobe", 32'(w), 32'd0);
        chk("abort_busy", 32'(bz), 32'd0);
        chk("abort_done", 32'(dn), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
          @(posedge clock); #1;
          sample(which, w, a, d, bz, dn);
          chk("post_abort_done", 32'(dn), 32'd0);
          chk("post_abort_strobe", 32'(w), 32'd0);
        end
        return;
      end
      cycles++;
      if (cycles > 200) begin
        chk("cycle_budget", 32'(presented), 32'(n));
        break;
      end
    end
    hold = 1'b0; set_start(which, 1'b0);
    @(posedge clock); #1;
    sample(which, w, a, d, bz, dn);
    chk("done_pulse", 32'(dn), 32'd1);
    chk("done_strobe", 32'(w), 32'd0);
    chk("done_busy", 32'(bz), 32'd0);
    @(posedge clock); #1;
    sample(which, w, a, d, bz, dn);
    chk("done_cleared", 32'(dn), 32'd0);
    chk("idle_strobe", 32'(w), 32'd0);
    chk("idle_busy", 32'(bz), 32'd0);
    $display("req which=%0d value=%08h base=%0d text=%s chars=%0d", which, v, b, txt, presented);
  endtask

  initial begin
    #50;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_strobe", 32'(wr_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_req(0, 32'h00400020, 12'd100, -1, 0, 1'b0, 0, 1'b0);
    run_req(0, 32'hDEADBEEF, 12'd500, -1, 0, 1'b0, 0, 1'b0);
    run_req(1, 32'hDEADBEEF, 12'd500, -1, 0, 1'b0, 0, 1'b0);
    run_req(0, 32'hCAFE0123, 12'd2397, -1, 0, 1'b0, 0, 1'b0);
    run_req(1, 32'h00009A5F, 12'd2398, -1, 0, 1'b0, 0, 1'b0);
    run_req(0, 32'h89ABCDEF, 12'd40, 2, 3, 1'b0, 0, 1'b0);
    run_req(0, 32'hA5A5A5A5, 12'd300, -1, 0, 1'b0, 0, 1'b1);
    run_req(1, 32'h0000ABCD, 12'd0, -1, 0, 1'b0, 0, 1'b1);
    run_req(0, 32'h76543210, 12'd2500, -1, 0, 1'b0, 0, 1'b0);
    run_req(0, 32'hFEDCBA98, 12'd1200, -1, 0, 1'b0, 4, 1'b0);
    run_req(0, 32'h13579BDF, 12'd1200, -1, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_req($urandom_range(0, 1), $urandom, 12'($urandom_range(0, 4095)), -1, 0, 1'b1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
